// File: rtl/scm_access_ctrl.sv
// Request-side sequencer for the latch-based memory: decodes word requests into DGWCLK/RWL strobes.
// Latency: a write takes 4 cycles, and a read gives rsp_valid 3 cycles after acceptance.
// Backpressure: req_ready is high only in IDLE; there is no response backpressure.
module scm_access_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic [(1<<ADDR_WIDTH)-1:0]   DGWCLK,
    output logic [(1<<ADDR_WIDTH)-1:0]   RWL,
    output logic [DATA_WIDTH-1:0]        DIN,
    input  logic [DATA_WIDTH-1:0]        DOUT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_SETUP   = 3'd1;
    localparam logic [2:0] W_PULSE   = 3'd2;
    localparam logic [2:0] W_HOLD    = 3'd3;
    localparam logic [2:0] R_DRIVE   = 3'd4;
    localparam logic [2:0] R_CAPTURE = 3'd5;
    localparam logic [2:0] R_RESP    = 3'd6;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;

    function automatic logic [DEPTH-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [DEPTH-1:0] one;
        one = DEPTH'(1);
        return one << a;
    endfunction

    // Every strobe comes straight from a flop, so DGWCLK/RWL cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            DGWCLK    <= '0;
            RWL       <= '0;
            DIN       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        if (req_we) begin
                            state <= W_SETUP;
                            DIN   <= req_wdata;
                        end else begin
                            state <= R_DRIVE;
                            RWL   <= decode(req_addr);
                        end
                    end
                end
                W_SETUP: begin
                    state  <= W_PULSE;
                    DGWCLK <= decode(addr_q);
                end
                W_PULSE: begin
                    state  <= W_HOLD;
                    DGWCLK <= '0;
                end
                W_HOLD: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                R_DRIVE: begin
                    state <= R_CAPTURE;
                end
                // DOUT has settled for a full cycle behind the word line; sample it now.
                R_CAPTURE: begin
                    state     <= R_RESP;
                    RWL       <= '0;
                    rsp_rdata <= DOUT;
                    rsp_valid <= 1'b1;
                end
                R_RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    DGWCLK    <= '0;
                    RWL       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scm_access_ctrl.sv
// Bench for scm_access_ctrl with a behavioural latch-array model behind DGWCLK/RWL.
module tb_scm_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] DGWCLK;
    logic [7:0] RWL;
    logic [7:0] DIN;
    logic [7:0] DOUT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       hold;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] mem [8];

    always #5 clk = ~clk;

    scm_access_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .DGWCLK    (DGWCLK),
        .RWL       (RWL),
        .DIN       (DIN),
        .DOUT      (DOUT)
    );

    // Latch array: transparent while the word's gated clock is high.
    always @* begin
        for (int w = 0; w < 8; w++)
            if (DGWCLK[w]) mem[w] = DIN;
    end

    always @* begin
        DOUT = '0;
        for (int w = 0; w < 8; w++)
            if (RWL[w]) DOUT = DOUT | mem[w];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] oh(input logic [2:0] a);
        logic [7:0] one;
        one = 8'd1;
        return one << a;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("no_overlap", 32'((|DGWCLK) && (|RWL)), 32'd0);
            check("dgwclk_onehot0", 32'($countones(DGWCLK) > 1), 32'd0);
            check("rwl_onehot0", 32'($countones(RWL) > 1), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_dgwclk"}, 32'(DGWCLK), 32'd0);
        check({tag, "_rwl"}, 32'(RWL), 32'd0);
    endtask

    task automatic do_req(input vec_t v);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        step();
        // Scramble inputs while busy; the captured request must be unaffected.
        if (v.hold) begin
            req_we    = ~v.we;
            req_addr  = v.addr ^ 3'd7;
            req_wdata = ~v.wdata;
        end else begin
            req_valid = 1'b0;
        end
        if (v.we) begin
            check("w1_ready", 32'(req_ready), 32'd0);
            check("w1_din", 32'(DIN), 32'(v.wdata));
            check("w1_dgwclk", 32'(DGWCLK), 32'd0);
            step();
            check("w2_dgwclk", 32'(DGWCLK), 32'(oh(v.addr)));
            check("w2_din", 32'(DIN), 32'(v.wdata));
            step();
            check("w3_dgwclk", 32'(DGWCLK), 32'd0);
            check("w3_din", 32'(DIN), 32'(v.wdata));
        end else begin
            check("r1_ready", 32'(req_ready), 32'd0);
            check("r1_rwl", 32'(RWL), 32'(oh(v.addr)));
            check("r1_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
            check("r2_rwl", 32'(RWL), 32'(oh(v.addr)));
            check("r2_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
            check("r3_rwl", 32'(RWL), 32'd0);
            check("r3_rsp_valid", 32'(rsp_valid), 32'd1);
            check("r3_rsp_rdata", 32'(rsp_rdata), 32'(v.rdata));
        end
        step();
        check_idle_outputs("c4");
        if (v.we) check("c4_din_retained", 32'(DIN), 32'(v.wdata));
        else      check("c4_rdata_retained", 32'(rsp_rdata), 32'(v.rdata));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        vecs.push_back('{1'b1, 3'd1, 8'hA5, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'hFF, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 3'(i), 8'(i * 17), 8'h00, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 3'(i), 8'h00, 8'(i * 17), 1'b0});
        vecs.push_back('{1'b1, 3'd5, 8'h5A, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h5A, 1'b1});
        vecs.push_back('{1'b1, 3'd5, 8'hC3, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'hC3, 1'b1});
        vecs.push_back('{1'b1, 3'd5, 8'h0F, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h0F, 1'b0});

        // Power-on reset, then a mid-run reset pulse.
        #12;
        check_idle_outputs("por");
        check("por_din", 32'(DIN), 32'd0);
        check("por_rdata", 32'(rsp_rdata), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_during");
        step();
        check_idle_outputs("rst_held");
        #3 rst_n = 1'b1;
        step();
        check_idle_outputs("rst_after");
        check("rst_after_din", 32'(DIN), 32'd0);

        foreach (vecs[i]) do_req(vecs[i]);

        // Reset in W_PULSE truncates the gated-clock pulse.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd6; req_wdata = 8'h99;
        step();
        req_valid = 1'b0;
        step();
        check("wp_pre_dgwclk", 32'(DGWCLK), 32'(oh(3'd6)));
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("wp_rst");
        check("wp_rst_din", 32'(DIN), 32'd0);
        #4 rst_n = 1'b1;
        step();
        check_idle_outputs("wp_after");

        // Reset in R_CAPTURE drops RWL and suppresses the response.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        step();
        req_valid = 1'b0;
        step();
        check("rc_pre_rwl", 32'(RWL), 32'(oh(3'd3)));
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rc_rst");
        #4 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rc_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check_idle_outputs("rc_after");

        do_req('{1'b1, 3'd3, 8'h3C, 8'h00, 1'b0});
        do_req('{1'b0, 3'd3, 8'h00, 8'h3C, 1'b0});

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
